// File: rtl/spi_pkg.sv
// Shared types and per-mode bit counts for the display SPI master.
package spi_pkg;

  typedef enum logic [1:0] {
    WRITE_8  = 2'd0,
    WRITE_16 = 2'd1,
    WR8_RD8  = 2'd2,
    WR8_RD24 = 2'd3
  } spi_mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TX   = 2'd1,
    S_RX   = 2'd2,
    S_DONE = 2'd3
  } spi_state_t;

  localparam int BIT_CNT_W = 5;
  localparam int TX_SR_W   = 16;

  function automatic logic [BIT_CNT_W-1:0] mode_tx_bits(spi_mode_t m);
    return (m == WRITE_16) ? 5'd16 : 5'd8;
  endfunction

  function automatic logic [BIT_CNT_W-1:0] mode_rx_bits(spi_mode_t m);
    case (m)
      WR8_RD8:  return 5'd8;
      WR8_RD24: return 5'd24;
      default:  return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/spi_controller.sv
// Mode-0 SPI master for the display: one transaction at a time, MSB first,
// optional read phase after an 8-bit command.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              display_csb
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;

  spi_state_t             state_q, state_d;
  spi_mode_t              mode_q;
  logic [TX_SR_W-1:0]     tx_sr_q;
  logic [TX_SR_W-1:0]     tx_load;
  logic [DIV_W-1:0]       div_q;
  logic [BIT_CNT_W-1:0]   bit_q;
  logic [BIT_CNT_W-1:0]   rx_bits;
  logic [DATA_W-1:0]      rx_q;
  logic                   sclk_q, mosi_q, csb_q;
  logic                   phase_end, bit_end;
  logic                   unused_hi;

  assign unused_hi = ^i_data[DATA_W-1:TX_SR_W];

  // Transmit data is left-justified so the next bit is always tx_sr_q[MSB].
  assign tx_load   = (spi_mode_t'(i_mode) == WRITE_16) ? i_data[TX_SR_W-1:0]
                                                       : {i_data[7:0], 8'h00};
  assign rx_bits   = mode_rx_bits(mode_q);
  assign phase_end = (div_q == DIV_W'(CLK_DIV - 1));
  assign bit_end   = phase_end && sclk_q && (bit_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_valid) state_d = S_TX;
      S_TX:    if (bit_end) state_d = (rx_bits != '0) ? S_RX : S_DONE;
      S_RX:    if (bit_end) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    i_ready = (state_q == S_IDLE);
    o_valid = (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q  <= WRITE_8;
      tx_sr_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      csb_q   <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            mode_q  <= spi_mode_t'(i_mode);
            tx_sr_q <= tx_load;
            mosi_q  <= tx_load[TX_SR_W-1];
            csb_q   <= 1'b0;
            sclk_q  <= 1'b0;
            div_q   <= '0;
            bit_q   <= mode_tx_bits(spi_mode_t'(i_mode)) - 5'd1;
            rx_q    <= '0;
          end
        end
        S_TX, S_RX: begin
          if (!phase_end) begin
            div_q <= div_q + DIV_W'(1);
          end else begin
            div_q <= '0;
            if (!sclk_q) begin
              // miso is captured on the same edge that raises spi_clk
              sclk_q <= 1'b1;
              if (state_q == S_RX) rx_q <= {rx_q[DATA_W-2:0], spi_miso};
            end else begin
              sclk_q <= 1'b0;
              if (bit_q != '0) begin
                bit_q <= bit_q - 5'd1;
                if (state_q == S_TX) begin
                  tx_sr_q <= tx_sr_q << 1;
                  mosi_q  <= tx_sr_q[TX_SR_W-2];
                end
              end else if (state_q == S_TX && rx_bits != '0) begin
                bit_q  <= rx_bits - 5'd1;
                mosi_q <= 1'b0;
              end else begin
                mosi_q <= 1'b0;
                csb_q  <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_data      = rx_q;
  assign spi_clk     = sclk_q;
  assign spi_mosi    = mosi_q;
  assign display_csb = csb_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed and random transactions against a bit-level SPI slave and a
// transaction-level expectation model.
module tb_spi_controller;

  localparam int CLK_DIV = 2;
  localparam int DATA_W  = 24;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_valid = 1'b0;
  logic              i_ready;
  logic [1:0]        i_mode = 2'd0;
  logic [DATA_W-1:0] i_data = '0;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              spi_clk;
  logic              spi_mosi;
  logic              spi_miso = 1'b0;
  logic              display_csb;

  spi_controller #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready),
    .i_mode(i_mode), .i_data(i_data), .o_data(o_data), .o_valid(o_valid),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .display_csb(display_csb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_err = 0;

  // slave model: record mosi on rising spi_clk, present reply bits on falling
  int          sl_cnt = 0;
  logic [31:0] cap_w = '0;
  int          tx_n = 8;
  int          rx_n = 0;
  logic [31:0] reply = '0;

  always @(posedge spi_clk or negedge display_csb) begin
    if (spi_clk) begin
      cap_w  = {cap_w[30:0], spi_mosi};
      sl_cnt = sl_cnt + 1;
    end else begin
      cap_w  = '0;
      sl_cnt = 0;
    end
  end

  always @(negedge spi_clk) begin
    if (sl_cnt >= tx_n && (sl_cnt - tx_n) < rx_n)
      spi_miso = reply[rx_n - 1 - (sl_cnt - tx_n)];
    else
      spi_miso = 1'b0;
  end

  int ov_pulses = 0;
  always @(negedge clk) if (o_valid) ov_pulses++;

  int done_cyc = 0;
  int last_low_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int tb_tx(input logic [1:0] m);
    return (m == 2'd1) ? 16 : 8;
  endfunction

  function automatic int tb_rx(input logic [1:0] m);
    return (m == 2'd2) ? 8 : (m == 2'd3) ? 24 : 0;
  endfunction

  task automatic run_txn(input logic [1:0] m, input logic [23:0] d, input logic [31:0] rep,
                         input bit hold, input bit b2b, input string tag);
    int tx, rx, n, acc, lows, t0;
    bit seen;
    logic [31:0] exp_mosi, exp_rd;
    tx = tb_tx(m);
    rx = tb_rx(m);
    n  = tx + rx;
    exp_mosi = (m == 2'd1) ? {16'h0, d[15:0]} : ({24'h0, d[7:0]} << rx);
    exp_rd   = (rx == 0) ? 32'h0 : (rep & ((32'h1 << rx) - 32'h1));
    reply = rep; tx_n = tx; rx_n = rx;
    i_valid = 1'b1; i_mode = m; i_data = d;
    t0 = 0;
    while (!i_ready && t0 < 300) begin @(negedge clk); t0++; end
    if (!i_ready) check({tag, "_ready_timeout"}, i_ready, 1);
    acc = cyc;
    if (b2b) begin
      check({tag, "_b2b_accept"}, acc - done_cyc, 1);
      check({tag, "_csb_gap"}, (acc + 1) - last_low_cyc - 1, 2);
    end
    @(negedge clk);
    // post-accept input changes must be ignored
    if (!hold) i_valid = 1'b0;
    i_data = ~d;
    i_mode = m ^ 2'b01;
    lows = 0; seen = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      if (!display_csb) begin lows++; last_low_cyc = cyc; end
      if (o_valid) seen = 1;
      else @(negedge clk);
    end
    check({tag, "_ovalid_seen"}, seen, 1);
    done_cyc = cyc;
    check({tag, "_latency"}, cyc - acc, n * 2 * CLK_DIV + 1);
    check({tag, "_csb_low"}, lows, n * 2 * CLK_DIV);
    check({tag, "_odata"}, o_data, exp_rd);
    check({tag, "_mosi"}, cap_w, exp_mosi);
    check({tag, "_nclk"}, sl_cnt, n);
    check({tag, "_done_ready"}, i_ready, 0);
    check({tag, "_done_sclk"}, spi_clk, 0);
    check({tag, "_done_csb"}, display_csb, 1);
    if (!hold) begin
      @(negedge clk);
      check({tag, "_ovalid_pulse"}, o_valid, 0);
      check({tag, "_odata_hold"}, o_data, exp_rd);
    end
  endtask

  initial begin
    int pulses;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", i_ready, 1);
    check("rst_ovalid", o_valid, 0);
    check("rst_odata", o_data, 0);
    check("rst_sclk", spi_clk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_csb", display_csb, 1);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(2'd0, 24'h0000A5, 32'h0,      0, 0, "w8_a5");
    run_txn(2'd1, 24'h001234, 32'h0,      0, 0, "w16_1234");
    run_txn(2'd2, 24'h000009, 32'h5C,     0, 0, "rd8");
    run_txn(2'd3, 24'h000004, 32'h009341, 0, 0, "rd24");
    run_txn(2'd0, 24'h00002A, 32'h0,      1, 0, "b2b_a");
    run_txn(2'd0, 24'h00002B, 32'h0,      0, 1, "b2b_b");

    // abort a WRITE_16 partway through with a two-cycle reset
    i_valid = 1'b1; i_mode = 2'd1; i_data = 24'h001234;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_mid_csb", display_csb, 0);
    pulses = ov_pulses;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_csb", display_csb, 1);
    check("abort_sclk", spi_clk, 0);
    check("abort_ready", i_ready, 1);
    check("abort_ovalid", o_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check("abort_no_pulse", ov_pulses - pulses, 0);
    check("abort_idle_csb", display_csb, 1);

    for (int r = 0; r < 16; r++) begin
      run_txn(2'($urandom_range(0, 3)), 24'($urandom), 32'($urandom), 0, 0, "rand");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
- Memory-mapped-peripheral-side SPI master, directly downstream of the rv32i_system peripheral bus.
- Drives the display pins spi_clk, spi_mosi and display_csb, and samples spi_miso.
- Accepts one transaction at a time over a valid/ready handshake, shifts it out in SPI mode 0, MSB first.
- Returns any read data with a one-cycle o_valid pulse.

Parameters:
- CLK_DIV, default 2: number of clk cycles per spi_clk half-period. Legal range 1..15.
- DATA_W, default 24: width of i_data and o_data; also the maximum read length.

Ports:
- clk  in  1  system clock (sysclk domain)
- rst_n  in  1  synchronous active-low reset
- i_valid  in  1  transaction request
- i_ready  out  1  controller idle, can accept a request
- i_mode  in  2  spi_mode_t: WRITE_8=0, WRITE_16=1, WR8_RD8=2, WR8_RD24=3
- i_data  in  DATA_W  transmit data, right-justified
- o_data  out  DATA_W  received data, right-justified, zero-extended
- o_valid  out  1  one-cycle pulse at transaction end
- spi_clk  out  1  SPI clock, idle low
- spi_mosi  out  1  SPI data out
- spi_miso  in  1  SPI data in
- display_csb  out  1  chip select, active low

Behaviour:
- Clocking and reset:
  - One clock (clk). Reset is synchronous and active-low (rst_n).
  - Reset values: i_ready=1, o_valid=0, o_data=0, spi_clk=0, spi_mosi=0, display_csb=1, state=S_IDLE.
  - Reset asserted mid-transaction aborts it. Outputs take reset values at the next clk edge. No o_valid is generated.
- States: S_IDLE, S_TX, S_RX, S_DONE.
- S_IDLE:
  - i_ready=1.
  - On a clk edge with i_valid=1: latch i_mode and i_data, clear o_data, go to S_TX.
- S_TX:
  - display_csb=0.
  - Transmit bits: WRITE_8 sends i_data[7:0]; WRITE_16 sends i_data[15:0]; the read modes send i_data[7:0]. Always MSB first.
  - Each bit lasts 2*CLK_DIV cycles: CLK_DIV cycles with spi_clk=0, then CLK_DIV cycles with spi_clk=1.
  - spi_mosi changes only while spi_clk=0. It is valid from the first low cycle of its bit.
  - After the last TX bit: go to S_RX for read modes, otherwise to S_DONE.
- S_RX:
  - Receives 8 bits (WR8_RD8) or 24 bits (WR8_RD24) with the same bit timing. spi_mosi=0.
  - spi_miso is sampled on the clk edge where spi_clk goes 0->1, and shifted into o_data LSB-first-in (left shift).
  - Upper bits of o_data stay 0. There is no dummy-bit handling; software discards it.
- S_DONE (exactly one cycle):
  - spi_clk=0, display_csb=1, o_valid=1, i_ready=0.
  - Next state S_IDLE.
  - o_data holds its value until the next accept. It is 0 for write modes.
- Latency: o_valid is asserted exactly (Nbits*2*CLK_DIV + 1) cycles after the accept edge. Nbits = 8, 16, 16 or 32 for modes 0..3.
- Back-to-back: i_valid held high is accepted on the first S_IDLE cycle. display_csb is therefore high for at least 2 cycles (S_DONE + S_IDLE) between transactions.
- Busy: i_valid while i_ready=0 is ignored and not queued. Changes to i_data/i_mode after accept have no effect.
- Counters:
  - Divider counter width $clog2(CLK_DIV)+1; it wraps to 0 at each phase change.
  - Bit counter is 5 bits and counts down to 0. Phase ends when the counter is 0 and the high phase is complete.
- spi_clk, spi_mosi and display_csb are registered outputs (glitch-free).

Decomposition:
- Package spi_pkg: spi_mode_t enum (2 bits), spi_state_t enum, function mode_tx_bits(spi_mode_t), function mode_rx_bits(spi_mode_t).
- Single module; the divider and shift registers are small enough to inline. No sub-module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-WRITE_16 -> next edge display_csb=1, spi_clk=0, i_ready=1, no o_valid pulse.
- WRITE_8, CLK_DIV=2, i_data=0xA5 -> mosi bits 1,0,1,0,0,1,0,1 on 8 rising spi_clk edges; o_valid at accept+33 cycles; o_data=0.
- WRITE_16, i_data=0x1234 -> 16 bits sent MSB first; display_csb low for exactly 64 cycles; o_valid at accept+65.
- WR8_RD8, i_data=0x09, model returns 0x5C on miso -> o_data=0x00005C; mosi=0 throughout the RX phase.
- WR8_RD24, i_data=0x04, model returns 0x009341 -> o_data=0x009341; o_valid at accept+129.
- Back-to-back: i_valid held high across two WRITE_8 requests (0x2A, 0x2B) -> second accepted the cycle after o_valid; display_csb high exactly 2 cycles between them; a request asserted mid-transfer is not lost (held until accepted).
